// File: rtl/alu_md_unit.sv
// Execute-stage control: ALU decode table plus an iterative multiply/divide unit with HI/LO.
// Define ALU_MUL_FAST_EN to replace the shift-add multiplier with a single-cycle product.
module alu_md_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [3:0]       alucontrol,
  output logic             jumpreg,
  output logic             illegal,
  output logic             mdsel,
  output logic [WIDTH-1:0] mdresult,
  output logic             stall,
  output logic             busy
);
  localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000, F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010, F_MTLO  = 6'b010011;
  localparam logic [5:0] F_JR    = 6'b001000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi, lo, ma, mb, araw;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q, neg_r, is_div, dz;

  logic rtype, mul_f, div_f, sgn_f, mf, mt, start, sa, sb;
  logic [WIDTH-1:0] aabs, babs;

  assign rtype = (aluop == 4'b0010);
  assign mul_f = (funct == F_MULT) || (funct == F_MULTU);
  assign div_f = (funct == F_DIV)  || (funct == F_DIVU);
  assign sgn_f = ~funct[0];
  assign mf    = rtype && ((funct == F_MFHI) || (funct == F_MFLO));
  assign mt    = rtype && ((funct == F_MTHI) || (funct == F_MTLO));
  assign start = en && rtype && (mul_f || div_f) && (state == S_IDLE);
  assign sa    = sgn_f & srca[WIDTH-1];
  assign sb    = sgn_f & srcb[WIDTH-1];
  assign aabs  = sa ? -srca : srca;
  assign babs  = sb ? -srcb : srcb;

  assign busy     = (state != S_IDLE);
  assign stall    = start || (state == S_MUL) || (state == S_DIV) || (en && (mf || mt) && busy);
  assign mdsel    = mf;
  assign mdresult = mf ? ((funct == F_MFHI) ? hi : lo) : '0;

  always_comb begin
    alucontrol = 4'b1111;
    illegal    = 1'b0;
    jumpreg    = 1'b0;
    if (rtype) begin
      case (funct)
        6'b100000: alucontrol = 4'b0010;
        6'b100010: alucontrol = 4'b0110;
        6'b100100: alucontrol = 4'b0000;
        6'b100101: alucontrol = 4'b0001;
        6'b101010: alucontrol = 4'b0111;
        6'b100110: alucontrol = 4'b0011;
        6'b100111: alucontrol = 4'b0100;
        6'b000000: alucontrol = 4'b1000;
        6'b000010: alucontrol = 4'b1001;
        6'b101011: alucontrol = 4'b1011;
        F_JR:      jumpreg    = 1'b1;
        F_MULT, F_MULTU, F_DIV, F_DIVU,
        F_MFHI, F_MTHI, F_MFLO, F_MTLO: ;
        default:   illegal    = 1'b1;
      endcase
    end else begin
      case (aluop)
        4'b0000: alucontrol = 4'b0010;
        4'b0001: alucontrol = 4'b0110;
        4'b0100: alucontrol = 4'b0000;
        4'b0101: alucontrol = 4'b0001;
        4'b0111: alucontrol = 4'b0111;
        default: alucontrol = 4'b1111;
      endcase
    end
  end

  // One shift-add step: acc holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma : {WIDTH{1'b0}})};
  assign mul_next = {msum, acc[WIDTH-1:1]};

  // One restoring step: acc holds {remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]     drem, ddiff;
  logic               qbit;
  logic [2*WIDTH-1:0] div_next;
  assign drem     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ddiff    = drem - {1'b0, mb};
  assign qbit     = ~ddiff[WIDTH];
  assign div_next = {(qbit ? ddiff[WIDTH-1:0] : drem[WIDTH-1:0]), acc[WIDTH-2:0], qbit};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      ma     <= '0;
      mb     <= '0;
      araw   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ma     <= aabs;
            mb     <= babs;
            araw   <= srca;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            is_div <= div_f;
            dz     <= div_f && (srcb == '0);
            cnt    <= CNT_W'(WIDTH);
            if (div_f) begin
              acc   <= {{WIDTH{1'b0}}, aabs};
              state <= (srcb == '0) ? S_DONE : S_DIV;
            end else begin
`ifdef ALU_MUL_FAST_EN
              acc   <= {{WIDTH{1'b0}}, aabs} * {{WIDTH{1'b0}}, babs};
              state <= S_DONE;
`else
              acc   <= {{WIDTH{1'b0}}, babs};
              state <= S_MUL;
`endif
            end
          end else if (en && mt) begin
            if (funct == F_MTHI) hi <= srca;
            else                 lo <= srca;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_DONE;
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          if (dz) begin
            hi <= araw;
            lo <= '1;
          end else if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: decode sweep plus directed and random MD ops against an arithmetic model.
module tb_alu_md_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;

  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [3:0] aluop = 4'b0000;
  logic [5:0] funct = 6'b0;
  logic [W-1:0] srca = '0, srcb = '0;
  logic [3:0] alucontrol;
  logic jumpreg, illegal, mdsel, stall, busy;
  logic [W-1:0] mdresult;

  int tests = 0, fails = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .aluop(aluop), .funct(funct),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .jumpreg(jumpreg),
    .illegal(illegal), .mdsel(mdsel), .mdresult(mdresult), .stall(stall), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    en = e; aluop = op; funct = f; srca = a; srcb = b;
  endtask

  // Reference decode taken straight from the opcode tables; returns {illegal, jumpreg, alucontrol}.
  function automatic logic [5:0] ref_dec(input logic [3:0] op, input logic [5:0] f);
    if (op != 4'b0010) begin
      case (op)
        4'b0000: return {2'b00, 4'b0010};
        4'b0001: return {2'b00, 4'b0110};
        4'b0100: return {2'b00, 4'b0000};
        4'b0101: return {2'b00, 4'b0001};
        4'b0111: return {2'b00, 4'b0111};
        default: return {2'b00, 4'b1111};
      endcase
    end
    case (f)
      6'b100000: return {2'b00, 4'b0010};
      6'b100010: return {2'b00, 4'b0110};
      6'b100100: return {2'b00, 4'b0000};
      6'b100101: return {2'b00, 4'b0001};
      6'b101010: return {2'b00, 4'b0111};
      6'b100110: return {2'b00, 4'b0011};
      6'b100111: return {2'b00, 4'b0100};
      6'b000000: return {2'b00, 4'b1000};
      6'b000010: return {2'b00, 4'b1001};
      6'b101011: return {2'b00, 4'b1011};
      6'b001000: return {2'b01, 4'b1111};
      6'b011000, 6'b011001, 6'b011010, 6'b011011,
      6'b010000, 6'b010001, 6'b010010, 6'b010011: return {2'b00, 4'b1111};
      default: return {2'b10, 4'b1111};
    endcase
  endfunction

  // Architectural effect of an MD op on HI/LO, using plain 64-bit arithmetic.
  function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] up;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    case (f)
      F_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      F_MULTU: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      F_DIV, F_DIVU: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (f == F_DIV) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_stall(input logic [5:0] f, input logic [W-1:0] b);
    if (f == F_DIV || f == F_DIVU) return (b == 0) ? 1 : W + 1;
`ifdef ALU_MUL_FAST_EN
    return 1;
`else
    return W + 1;
`endif
  endfunction

  // Issue one MD op and hold it until it retires; ends at a falling edge with inputs idle.
  task automatic md_op(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    drive(1'b1, 4'b0010, f, a, b);
    #1;
    while (stall && n < 200) begin n++; @(negedge clk); #1; end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall(f, b)));
    chk({tag, "_done_busy"}, {63'b0, busy}, 64'd1);
    model(f, a, b);
    drive(1'b0, 4'b0000, 6'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic read_hilo(input string tag);
    drive(1'b1, 4'b0010, F_MFHI, '0, '0);
    #1;
    chk({tag, "_hi"}, {32'b0, mdresult}, {32'b0, m_hi});
    chk({tag, "_mf_stall"}, {63'b0, stall}, 64'd0);
    @(negedge clk);
    drive(1'b1, 4'b0010, F_MFLO, '0, '0);
    #1;
    chk({tag, "_lo"}, {32'b0, mdresult}, {32'b0, m_lo});
    chk({tag, "_mdsel"}, {63'b0, mdsel}, 64'd1);
    @(negedge clk);
    drive(1'b0, 4'b0000, 6'b0, '0, '0);
  endtask

  initial begin
    logic [5:0] f, ops [6];
    logic [W-1:0] a, b;
    int n;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_mdsel_mdresult", {31'b0, mdsel, mdresult}, 64'd0);
    @(negedge clk);
    read_hilo("rst");

    // Decode: directed plan cases then a full sweep
    drive(1'b0, 4'b0010, 6'b100110, '0, '0); #1;
    chk("dec_xor", {58'b0, illegal, alucontrol}, {59'b0, 5'b00011});
    drive(1'b0, 4'b0010, 6'b111111, '0, '0); #1;
    chk("dec_bad", {58'b0, illegal, alucontrol}, {59'b0, 5'b11111});
    drive(1'b0, 4'b0010, 6'b001000, '0, '0); #1;
    chk("dec_jr", {63'b0, jumpreg}, 64'd1);
    drive(1'b0, 4'b0001, 6'b100000, '0, '0); #1;
    chk("dec_sub", {60'b0, alucontrol}, 64'b0110);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 4'b0010, 6'(i), '0, '0); #1;
      chk($sformatf("dec_f%0d", i), {58'b0, illegal, jumpreg, alucontrol}, {58'b0, ref_dec(4'b0010, 6'(i))});
    end
    for (int i = 0; i < 16; i++) begin
      f = 6'($urandom);
      drive(1'b0, 4'(i), f, '0, '0); #1;
      chk($sformatf("dec_op%0d", i), {58'b0, illegal, jumpreg, alucontrol}, {58'b0, ref_dec(4'(i), f)});
    end
    drive(1'b0, 4'b0000, 6'b0, '0, '0);
    @(negedge clk);

    // Directed MD cases
    md_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd5);  read_hilo("mult_neg");
    md_op("multu", F_MULTU, 32'hFFFFFFFD, 32'd5);    read_hilo("multu");
    md_op("divu", F_DIVU, 32'd100, 32'd7);           read_hilo("divu");
    md_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2);    read_hilo("div_neg");
    md_op("div0", F_DIV, 32'd5, 32'd0);              read_hilo("div0");
    md_op("mul_big", F_MULT, 32'h10000, 32'h10000);  read_hilo("mul_big");
    md_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF); read_hilo("div_ovf");

    // MFLO presented while DIV is busy
    drive(1'b1, 4'b0010, F_DIV, 32'd1000, 32'hFFFFFFFD);
    #1;
    n = 0;
    for (int i = 0; i < 5; i++) begin if (stall) n++; @(negedge clk); #1; end
    drive(1'b1, 4'b0010, F_MFLO, '0, '0);
    #1;
    while (stall && n < 200) begin n++; @(negedge clk); #1; end
    model(F_DIV, 32'd1000, 32'hFFFFFFFD);
    chk("mf_busy_stall_cycles", 64'(n), 64'(W + 2));
    chk("mf_busy_idle", {63'b0, busy}, 64'd0);
    chk("mf_busy_mdsel", {63'b0, mdsel}, 64'd1);
    chk("mf_busy_lo", {32'b0, mdresult}, {32'b0, m_lo});
    @(negedge clk); #1;
    chk("mf_busy_no_restart", {62'b0, busy, stall}, 64'd0);
    drive(1'b0, 4'b0000, 6'b0, '0, '0);
    @(negedge clk);

    // MTHI then MFHI back to back
    drive(1'b1, 4'b0010, F_MTHI, 32'h1234, '0); #1;
    chk("mthi_stall", {63'b0, stall}, 64'd0);
    model(F_MTHI, 32'h1234, '0);
    @(negedge clk);
    drive(1'b1, 4'b0010, F_MFHI, '0, '0); #1;
    chk("mfhi_val", {32'b0, mdresult}, 64'h1234);
    chk("mfhi_stall", {63'b0, stall}, 64'd0);
    drive(1'b0, 4'b0000, 6'b0, '0, '0);
    @(negedge clk);

    // Random ops against the model
    for (int it = 0; it < 24; it++) begin
      f = ops[$urandom_range(0, 5)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(1, 20)); end
        default: b = $urandom;
      endcase
      if (f == F_MTHI || f == F_MTLO) begin
        drive(1'b1, 4'b0010, f, a, b); #1;
        chk($sformatf("rnd%0d_mt_stall", it), {63'b0, stall}, 64'd0);
        model(f, a, b);
        @(negedge clk);
        drive(1'b0, 4'b0000, 6'b0, '0, '0);
      end else begin
        md_op($sformatf("rnd%0d", it), f, a, b);
      end
      read_hilo($sformatf("rnd%0d", it));
    end

    // Reset during MULT
    drive(1'b1, 4'b0010, F_MULT, 32'd12345, 32'd678);
    #1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); #1; end
    drive(1'b0, 4'b0000, 6'b0, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_stall", {63'b0, stall}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    read_hilo("rst_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Next-generation execute-stage control: the ALU decode table (extended with XOR/NOR/SLL/SRL/SLTU) plus an iterative multiply/divide unit with HI/LO registers.
- Parametrised in datapath WIDTH.
- Sits between the main decoder and the ALU/result mux.
- Multi-cycle MD ops stall the PC through a `stall` output.

Parameters:
- WIDTH, 32, operand / HI / LO width (even, ≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  instruction valid this cycle.
- aluop  in  4  from main decoder; 4'b0010 = R-type (decode funct).
- funct  in  6  instruction funct field.
- srca  in  WIDTH  rs operand.
- srcb  in  WIDTH  rt operand.
- alucontrol  out  4  ALU operation select.
- jumpreg  out  1  funct==6'b001000 and aluop==4'b0010.
- illegal  out  1  R-type with unrecognised funct.
- mdsel  out  1  writeback takes mdresult (MFHI/MFLO).
- mdresult  out  WIDTH  HI or LO per funct.
- stall  out  1  hold PC / suppress register writes.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset: state=IDLE, HI=LO=0, counter=0; stall=busy=mdsel=0; mdresult=0.
- Decode (combinational) when aluop is not 4'b0010:
  - 0000 → 0010 (add), 0001 → 0110 (sub), 0100 → 0000 (and), 0101 → 0001 (or), 0111 → 0111 (slt).
  - Any other aluop → 1111, illegal=0.
- Decode when aluop=4'b0010:
  - funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111.
  - funct 100110 (XOR) → 0011, 100111 (NOR) → 0100, 000000 (SLL) → 1000, 000010 (SRL) → 1001, 101011 (SLTU) → 1011.
  - MD functs (below) and 001000 → 1111 with illegal=0.
  - Anything else → 1111 with illegal=1. The output is never x.
- MD functs: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO.
- `start` = en & aluop==0010 & funct in {MULT, MULTU, DIV, DIVU} & state==IDLE.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + start, mul: latch |srca|, |srcb| (raw values if unsigned) and the result sign; counter=WIDTH; go to MUL.
  - IDLE + start, div with srcb≠0: same latching; go to DIV.
  - IDLE + start, div with srcb==0: go directly to DONE.
  - MUL: one shift-add step per cycle on a 2·WIDTH accumulator; counter decrements; when counter reaches 1, go to DONE.
  - DIV: one restoring-division step per cycle; same count; then go to DONE.
  - DONE: write HI/LO on the edge with sign fix-up applied; go to IDLE.
    - Signed product: negate if signs differ.
    - Quotient sign = sa^sb; remainder takes the dividend's sign.
    - Divide-by-zero: LO = all ones, HI = srca.
- stall = start | state==MUL | state==DIV.
  - stall is 0 in DONE, so the held instruction retires on the DONE edge and does not restart (state≠IDLE).
  - Timing: stall high WIDTH+1 cycles; instruction occupies WIDTH+2 cycles (divide-by-zero: stall 1 cycle, 2 cycles total).
- MFHI/MFLO: mdsel=1, mdresult=HI/LO.
  - If state≠IDLE, stall=1 until the FSM is back in IDLE; the result is read from the updated HI/LO.
  - mdresult=0 when mdsel=0.
- MTHI/MTLO: write srca to HI/LO on the edge when en & state==IDLE; stall while busy.
- en=0: no state change; decode outputs still track inputs.
- Reset mid-operation: immediate return to IDLE, HI/LO cleared, partial result discarded, stall=0 next cycle.

Optional Feature:
- ALU_MUL_FAST_EN defined: MULT/MULTU use a combinational WIDTH×WIDTH product.
  - IDLE + start → DONE directly; stall high 1 cycle; 2 cycles total.
  - DIV unchanged; state MUL is unreachable.
- ALU_MUL_FAST_EN undefined: iterative multiply as above.
- Architectural HI/LO results are identical either way.

Test Plan:
- Decode sweep: aluop 0010, funct 100110 → alucontrol 0011, illegal 0; funct 111111 → 1111, illegal 1; funct 001000 → jumpreg 1; aluop 0001 → 0110.
- MULT srca=FFFFFFFD (−3), srcb=5 → stall high 33 cycles; then HI=FFFFFFFF, LO=FFFFFFF1; MULTU same operands → HI=00000004, LO=FFFFFFF1.
- DIVU 100/7 → LO=0000000E, HI=00000002; DIV −7/2 → LO=FFFFFFFD, HI=FFFFFFFF; DIV 5/0 → stall 1 cycle, LO=FFFFFFFF, HI=00000005.
- MFLO presented while DIV busy → stall held until IDLE; mdsel=1; mdresult equals the new LO; no double start.
- MTHI 0x1234 then MFHI → mdresult=00001234, no stall; reset asserted mid-MULT (cycle 10) → next cycle busy=0, stall=0, HI=LO=0.
- With ALU_MUL_FAST_EN: MULT 0x10000 × 0x10000 → stall 1 cycle, HI=00000001, LO=00000000.
